// File: rtl/tcm_rw_port_arbiter.sv
// Two-requester arbiter for the TCM read/write port: LSU vs program loader.
// Round-robin with core priority from idle, loader burst lock capped by MAX_BURST.
module tcm_rw_port_arbiter #(
   parameter int unsigned ADDR_W    = 12,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              cpu_rst,
   input  logic              lsu_req,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_gnt,
   output logic              lsu_rvalid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic              ldr_lock,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StLsu, StLdr, StLock} state_e;

   localparam int unsigned CntW = $clog2(MAX_BURST + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rd_q, rd_d;
   logic            owner_q, owner_d;  // 1 = loader owns the pending read
   logic            lsu_win, ldr_win;

   always_comb begin
      lsu_win = 1'b0;
      ldr_win = 1'b0;
      if (lsu_req && ldr_req) begin
         unique case (state_q)
            StLock:  begin
               if (cnt_q == CntMax) lsu_win = 1'b1;
               else                 ldr_win = 1'b1;
            end
            StLsu:   ldr_win = 1'b1;
            StLdr:   lsu_win = 1'b1;
            default: lsu_win = 1'b1;
         endcase
      end else begin
         lsu_win = lsu_req;
         ldr_win = ldr_req;
      end
      // No grant can be issued while reset is held.
      lsu_win = lsu_win & cpu_rst;
      ldr_win = ldr_win & cpu_rst;
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      state_d   = StIdle;
      cnt_d     = '0;
      rd_d      = 1'b0;
      owner_d   = 1'b0;
      if (lsu_win) begin
         mem_we    = lsu_we;
         mem_addr  = lsu_addr;
         mem_wdata = lsu_wdata;
         state_d   = StLsu;
         rd_d      = ~lsu_we;
      end else if (ldr_win) begin
         mem_we    = ldr_we;
         mem_addr  = ldr_addr;
         mem_wdata = ldr_wdata;
         state_d   = ldr_lock ? StLock : StLdr;
         rd_d      = ~ldr_we;
         owner_d   = 1'b1;
         if (ldr_lock) cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge cpu_rst) begin
      if (!cpu_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         owner_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         owner_q <= owner_d;
      end
   end

   assign lsu_gnt    = lsu_win;
   assign ldr_gnt    = ldr_win;
   assign lsu_stall  = lsu_req & ~lsu_win;
   assign lsu_rvalid = rd_q & ~owner_q;
   assign ldr_rvalid = rd_q & owner_q;
   assign lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
   assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_tcm_rw_port_arbiter.sv
// Directed bench for tcm_rw_port_arbiter with a behavioural synchronous TCM and a read scoreboard.
module tb_tcm_rw_port_arbiter;

   logic        clk = 1'b0;
   logic        cpu_rst;
   logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_stall;
   logic [11:0] lsu_addr;
   logic [31:0] lsu_wdata, lsu_rdata;
   logic        ldr_req, ldr_we, ldr_lock, ldr_gnt, ldr_rvalid;
   logic [11:0] ldr_addr;
   logic [31:0] ldr_wdata, ldr_rdata;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic        pl_en;
   logic [11:0] pl_addr;
   logic [31:0] pl_data;
   logic [31:0] mem [0:4095];

   typedef struct packed {
      logic        owner;
      logic [31:0] data;
   } rd_exp_t;
   rd_exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;

   tcm_rw_port_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_BURST(16)) dut (
      .clk(clk), .cpu_rst(cpu_rst),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_stall(lsu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_lock(ldr_lock), .ldr_addr(ldr_addr),
      .ldr_wdata(ldr_wdata), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pl_en)       mem[pl_addr] <= pl_data;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_grant(input string tag, input logic exp_lsu, input logic exp_ldr);
      chk1({tag, "_lsu_gnt"}, lsu_gnt, exp_lsu);
      chk1({tag, "_ldr_gnt"}, ldr_gnt, exp_ldr);
      chk1({tag, "_stall"}, lsu_stall, lsu_req & ~exp_lsu);
   endtask

   task automatic chk_quiet(input string tag);
      chk1({tag, "_lsu_gnt"}, lsu_gnt, 1'b0);
      chk1({tag, "_ldr_gnt"}, ldr_gnt, 1'b0);
      chk1({tag, "_lsu_rvalid"}, lsu_rvalid, 1'b0);
      chk1({tag, "_ldr_rvalid"}, ldr_rvalid, 1'b0);
      chk({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
      chk({tag, "_ldr_rdata"}, ldr_rdata, 32'h0);
      chk1({tag, "_mem_we"}, mem_we, 1'b0);
      chk({tag, "_mem_addr"}, {20'h0, mem_addr}, 32'h0);
   endtask

   task automatic chk_return(input string tag);
      rd_exp_t e;
      n_tests++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL %s_sb: observed empty scoreboard expected pending read", tag);
      end else begin
         e = sb.pop_front();
         chk1({tag, "_lsu_rvalid"}, lsu_rvalid, ~e.owner);
         chk1({tag, "_ldr_rvalid"}, ldr_rvalid, e.owner);
         chk({tag, "_lsu_rdata"}, lsu_rdata, e.owner ? 32'h0 : e.data);
         chk({tag, "_ldr_rdata"}, ldr_rdata, e.owner ? e.data : 32'h0);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      cpu_rst = 1'b0;
      {lsu_req, lsu_we, ldr_req, ldr_we, ldr_lock} = '0;
      lsu_addr = '0; lsu_wdata = '0; ldr_addr = '0; ldr_wdata = '0;
      pl_en = 1'b1; pl_addr = 12'h010; pl_data = 32'hDEADBEEF;
      @(negedge clk);
      chk_quiet("reset");
      next_cycle();
      pl_en = 1'b0;
      cpu_rst = 1'b1;

      // LSU read with single-cycle return
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 12'h010;
      @(negedge clk);
      chk_grant("t1", 1'b1, 1'b0);
      chk("t1_mem_addr", {20'h0, mem_addr}, 32'h010);
      chk1("t1_mem_we", mem_we, 1'b0);
      sb.push_back('{owner: 1'b0, data: 32'hDEADBEEF});
      next_cycle();
      lsu_req = 1'b0;
      @(negedge clk);
      chk_return("t1_ret");
      next_cycle();

      // Alternating grants without lock, starting from idle
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 12'h100; lsu_wdata = 32'h1111;
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 12'h200; ldr_wdata = 32'h2222;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk_grant($sformatf("t2_%0d", i), (i % 2) == 0, (i % 2) == 1);
         if (i == 1) begin
            chk("t2_ldr_wdata", mem_wdata, 32'h2222);
            chk1("t2_ldr_we", mem_we, 1'b1);
         end
         next_cycle();
      end
      lsu_req = 1'b0; ldr_req = 1'b0;
      next_cycle();

      // Locked burst: LSU wins from idle, then 16 LDR, 1 LSU, 16 LDR
      lsu_req = 1'b1; ldr_req = 1'b1; ldr_lock = 1'b1;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         chk_grant($sformatf("t3_%0d", i), (i == 0) || (i == 17), (i != 0) && (i != 17));
         next_cycle();
      end
      lsu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
      @(negedge clk);
      chk_quiet("t3_idle");
      next_cycle();

      // Lock dropped mid-burst at cnt=5 with LSU waiting
      lsu_req = 1'b1; ldr_req = 1'b1; ldr_lock = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i == 6) ldr_lock = 1'b0;
         @(negedge clk);
         chk_grant($sformatf("t6_%0d", i), (i == 0) || (i == 7), !((i == 0) || (i == 7)));
         next_cycle();
      end
      lsu_req = 1'b0; ldr_req = 1'b0;
      next_cycle();

      // Loader write then LSU read of the same word, then pipelined loader read
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 12'h004; ldr_wdata = 32'h00000013;
      @(negedge clk);
      chk_grant("t4_wr", 1'b0, 1'b1);
      chk("t4_wr_data", mem_wdata, 32'h00000013);
      next_cycle();
      ldr_req = 1'b0;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 12'h004;
      @(negedge clk);
      chk_grant("t4_rd", 1'b1, 1'b0);
      chk1("t4_no_wr_return", lsu_rvalid | ldr_rvalid, 1'b0);
      sb.push_back('{owner: 1'b0, data: 32'h00000013});
      next_cycle();
      lsu_req = 1'b0;
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 12'h010;
      @(negedge clk);
      chk_grant("t4_ldr_rd", 1'b0, 1'b1);
      chk_return("t4_lsu_ret");
      sb.push_back('{owner: 1'b1, data: 32'hDEADBEEF});
      next_cycle();
      ldr_req = 1'b0;
      @(negedge clk);
      chk_return("t4_ldr_ret");
      next_cycle();

      // Reset between a read grant and its return drops the read
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 12'h010;
      @(negedge clk);
      chk_grant("t5_rd", 1'b1, 1'b0);
      #1;
      cpu_rst = 1'b0; lsu_req = 1'b0;
      @(negedge clk);
      chk_quiet("t5_in_reset");
      next_cycle();
      cpu_rst = 1'b1;
      @(negedge clk);
      chk_quiet("t5_released");
      next_cycle();
      // Idle state after reset gives the tie to the LSU
      lsu_req = 1'b1; lsu_we = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1;
      @(negedge clk);
      chk_grant("t5_tie", 1'b1, 1'b0);
      next_cycle();
      lsu_req = 1'b0; ldr_req = 1'b0;
      @(negedge clk);
      chk1("t5_sb_empty", sb.size() == 0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
